// File: rtl/mux8_outreg_frame_config_pkg.sv
// Shared constants for the mux8 output register BEL: config bit positions
// and tap indices (0=AB, 1=AD, 2=AH, 3=EF).
package mux8_outreg_frame_config_pkg;

    localparam int NUM_TAPS  = 4;

    localparam int BYP_LSB   = 0;
    localparam int INIT_LSB  = 4;
    localparam int SHIFT_BIT = 8;
    localparam int SRE_BIT   = 9;
    localparam int ENI_BIT   = 10;

    localparam int TAP_AB    = 0;
    localparam int TAP_AD    = 1;
    localparam int TAP_AH    = 2;
    localparam int TAP_EF    = 3;

endpackage

// File: rtl/mux8_outreg_frame_config_if.sv
// Switch-matrix side signals of the output register BEL: enable, the four
// mux taps coming in, the four (possibly bypassed) taps and serial out.
interface mux8_outreg_frame_config_if;

    logic EN;
    logic I_AB;
    logic I_AD;
    logic I_AH;
    logic I_EF;
    logic Q_AB;
    logic Q_AD;
    logic Q_AH;
    logic Q_EF;
    logic SO;

    modport master (
        output EN, I_AB, I_AD, I_AH, I_EF,
        input  Q_AB, Q_AD, Q_AH, Q_EF, SO
    );

    modport slave (
        input  EN, I_AB, I_AD, I_AH, I_EF,
        output Q_AB, Q_AD, Q_AH, Q_EF, SO
    );

endinterface

// File: rtl/mux8_outreg_frame_config_outreg_ff_cell.sv
// One output tap: a flop with sync init, enable and parallel/shift D-select,
// followed by a registered-or-bypass output mux.

// Plain 2:1 mux used for the bypass selection.
module my_mux2 (
    input  logic A0,
    input  logic A1,
    input  logic S,
    output logic X
);

    assign X = S ? A1 : A0;

endmodule

module outreg_ff_cell (
    input  logic clk,
    input  logic srst,      // already gated by the SR enable bit
    input  logic init,      // value loaded on reset
    input  logic en,        // effective enable
    input  logic shift,     // 1: load from chain neighbour instead of the tap
    input  logic d_par,     // tap input from the mux
    input  logic d_shift,   // previous stage of the shift chain
    input  logic byp,       // bypass request, ignored in shift mode
    output logic r,
    output logic q
);

    logic r_reg;
    logic byp_eff;

    // Reset beats enable; the register keeps loading even while bypassed so
    // dropping the bypass later shows the most recent capture immediately.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_reg <= init;
        end else if (en) begin
            r_reg <= shift ? d_shift : d_par;
        end
    end

    assign r       = r_reg;
    assign byp_eff = byp & ~shift;

    my_mux2 u_byp_mux (
        .A0 (r_reg),
        .A1 (d_par),
        .S  (byp_eff),
        .X  (q)
    );

endmodule

// File: rtl/mux8_outreg_frame_config.sv
// Registered output stage for the 8-input mux BEL. Decodes the frame config
// bits, forms the effective enable and wires four cells into either four
// independent flops or a 4-bit shift chain (AB -> AD -> AH -> EF -> SO).
module mux8_outreg_frame_config
    import mux8_outreg_frame_config_pkg::*;
#(
    parameter int NoConfigBits = 11
) (
    input  logic                    UserCLK,
    input  logic                    SR,
    mux8_outreg_frame_config_if.slave bus,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    logic [NUM_TAPS-1:0] c_byp;
    logic [NUM_TAPS-1:0] c_init;
    logic                c_shift;
    logic                c_sre;
    logic                c_eni;

    logic                en_eff;
    logic                srst;
    logic [NUM_TAPS-1:0] d_vec;
    logic [NUM_TAPS-1:0] shift_in;
    logic [NUM_TAPS-1:0] r_vec;
    logic [NUM_TAPS-1:0] q_vec;

    assign c_byp   = ConfigBits[BYP_LSB  +: NUM_TAPS];
    assign c_init  = ConfigBits[INIT_LSB +: NUM_TAPS];
    assign c_shift = ConfigBits[SHIFT_BIT];
    assign c_sre   = ConfigBits[SRE_BIT];
    assign c_eni   = ConfigBits[ENI_BIT];

    assign en_eff  = c_eni | bus.EN;
    assign srst    = c_sre & SR;

    assign d_vec[TAP_AB] = bus.I_AB;
    assign d_vec[TAP_AD] = bus.I_AD;
    assign d_vec[TAP_AH] = bus.I_AH;
    assign d_vec[TAP_EF] = bus.I_EF;

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_cell
            // The chain head is fed from the AB tap; every other stage
            // takes the previous stage's register.
            if (gi == 0) begin : g_head
                assign shift_in[gi] = d_vec[TAP_AB];
            end else begin : g_link
                assign shift_in[gi] = r_vec[gi-1];
            end

            outreg_ff_cell u_cell (
                .clk     (UserCLK),
                .srst    (srst),
                .init    (c_init[gi]),
                .en      (en_eff),
                .shift   (c_shift),
                .d_par   (d_vec[gi]),
                .d_shift (shift_in[gi]),
                .byp     (c_byp[gi]),
                .r       (r_vec[gi]),
                .q       (q_vec[gi])
            );
        end
    endgenerate

    assign bus.Q_AB = q_vec[TAP_AB];
    assign bus.Q_AD = q_vec[TAP_AD];
    assign bus.Q_AH = q_vec[TAP_AH];
    assign bus.Q_EF = q_vec[TAP_EF];
    assign bus.SO   = r_vec[TAP_EF];

endmodule
